// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and a
// variable-latency instruction memory.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, one-entry
// return buffer for ID stalls, branch redirect/drain and the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PC_EN_IF,
    input  logic                     reg_FD_EN,
    input  logic                     reg_FD_stall,
    input  logic                     reg_FD_flush,
    input  logic                     Branch_ID,
    input  logic [31:0]              PC_target_ID,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              PC_IF,
    output logic [31:0]              PC_ID,
    output logic [31:0]              inst_ID,
    output logic                     valid_ID,
    output logic [1:0]               dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state, next_state;
    logic [31:0] next_pc;
    logic [31:0] drain_addr;
    logic [31:0] buf_inst;
    logic        capture;
    logic        req;
    logic        rsp;
    logic        advance;
    logic        redirect;
    logic        deliver_ok;
    logic [31:0] deliver_inst;
    logic [31:0] target;

    // Handshake: req/addr stay stable from assertion until the cycle ready is
    // seen with req high; that cycle completes the single outstanding request.
    // ready while req is low carries no meaning and is masked off.
    assign req            = (state == ST_FETCH) || (state == ST_DRAIN);
    assign rsp            = req & imem.imem_ready;
    assign imem.imem_req  = req;
    assign imem.imem_addr = (state == ST_DRAIN) ? drain_addr : PC_IF;
    assign dbg_state      = state;

    assign advance  = PC_EN_IF & ~reg_FD_stall & reg_FD_EN;
    assign redirect = PC_EN_IF & Branch_ID;
    assign target   = PC_target_ID & ~32'h3;

    // PC_IF is frozen in HOLD, so it still names the buffered instruction.
    assign deliver_ok   = advance & ~redirect &
                          (((state == ST_FETCH) & rsp) | (state == ST_HOLD));
    assign deliver_inst = (state == ST_HOLD) ? buf_inst : imem.imem_rdata;

    always_comb begin
        next_state = state;
        next_pc    = PC_IF;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state = ST_FETCH;
                if (redirect) next_pc = target;
            end
            ST_FETCH: begin
                if (redirect) begin
                    next_pc = target;
                    if (!rsp) next_state = ST_DRAIN;
                end else if (rsp) begin
                    if (advance) begin
                        next_pc = PC_IF + 32'd4;
                    end else begin
                        capture    = 1'b1;
                        next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    next_pc    = target;
                    next_state = ST_FETCH;
                end else if (advance) begin
                    next_pc    = PC_IF + 32'd4;
                    next_state = ST_FETCH;
                end
            end
            default: begin
                if (redirect) next_pc = target;
                if (rsp) next_state = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            PC_IF      <= RESET_PC;
            drain_addr <= 32'h0;
            buf_inst   <= NOP_INST;
            PC_ID      <= 32'h0;
            inst_ID    <= NOP_INST;
            valid_ID   <= 1'b0;
        end else begin
            state <= next_state;
            PC_IF <= next_pc;
            if (capture) buf_inst <= imem.imem_rdata;
            if ((state == ST_FETCH) && redirect && !rsp) drain_addr <= PC_IF;
            // Any IF/ID load that is not a real delivery becomes a bubble.
            if (reg_FD_EN) begin
                if (reg_FD_flush) begin
                    inst_ID  <= NOP_INST;
                    valid_ID <= 1'b0;
                end else if (!reg_FD_stall) begin
                    PC_ID <= PC_IF;
                    if (deliver_ok) begin
                        inst_ID  <= deliver_inst;
                        valid_ID <= 1'b1;
                    end else begin
                        inst_ID  <= NOP_INST;
                        valid_ID <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, wait states, ID stall/hold,
// branch drain, ignored branch, fetch-hit redirect and mid-request reset.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        fd_en;
  logic        fd_stall;
  logic        fd_flush;
  logic        branch;
  logic [31:0] target;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic [31:0] inst_id;
  logic        valid_id;
  logic [1:0]  st;
  logic        zw;
  logic        ready_drv;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .PC_EN_IF    (pc_en),
    .reg_FD_EN   (fd_en),
    .reg_FD_stall(fd_stall),
    .reg_FD_flush(fd_flush),
    .Branch_ID   (branch),
    .PC_target_ID(target),
    .imem        (imem_bus.master),
    .PC_IF       (pc_if),
    .PC_ID       (pc_id),
    .inst_ID     (inst_id),
    .valid_ID    (valid_id),
    .dbg_state   (st)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAB00_0000 | a;
  endfunction

  // memory model: zero-wait mode answers every request immediately
  always_comb begin
    imem_bus.imem_ready = zw ? imem_bus.imem_req : ready_drv;
    imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_en = 1'b1; fd_en = 1'b1; fd_stall = 1'b0; fd_flush = 1'b0;
    branch = 1'b0; target = 32'h0; zw = 1'b1; ready_drv = 1'b0;
    step(); step();
    checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL reset_pc_if: got %h exp %h", pc_if, 32'h0); end
    checks++; if (pc_id !== 32'h0) begin errors++; $display("FAIL reset_pc_id: got %h exp %h", pc_id, 32'h0); end
    checks++; if (inst_id !== NOP) begin errors++; $display("FAIL reset_inst: got %h exp %h", inst_id, NOP); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_id); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_bus.imem_req); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", st); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    step();
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL zw_state: got %0d exp 1", st); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL zw_first_valid: got %b exp 0", valid_id); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] e;
      a = 32'(4 * i);
      checks++; if (imem_bus.imem_addr !== a) begin errors++; $display("FAIL zw_addr: got %h exp %h", imem_bus.imem_addr, a); end
      exp_q.push_back(mem_word(a));
      step();
      e = exp_q.pop_front();
      checks++; if (pc_id !== a) begin errors++; $display("FAIL zw_pc_id: got %h exp %h", pc_id, a); end
      checks++; if (inst_id !== e) begin errors++; $display("FAIL zw_inst: got %h exp %h", inst_id, e); end
      checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b exp 1", valid_id); end
    end
  endtask

  task automatic test_hold();
    zw = 1'b0; ready_drv = 1'b1; fd_stall = 1'b1; pc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (st !== 2'd2) begin errors++; $display("FAIL hold_state: got %0d exp 2", st); end
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b exp 0", imem_bus.imem_req); end
      checks++; if (pc_if !== 32'h10) begin errors++; $display("FAIL hold_pc_if: got %h exp %h", pc_if, 32'h10); end
      checks++; if (pc_id !== 32'hC) begin errors++; $display("FAIL hold_pc_id: got %h exp %h", pc_id, 32'hC); end
      checks++; if (inst_id !== mem_word(32'hC)) begin errors++; $display("FAIL hold_inst: got %h exp %h", inst_id, mem_word(32'hC)); end
    end
    fd_stall = 1'b0; pc_en = 1'b1; ready_drv = 1'b0;
    step();
    checks++; if (pc_id !== 32'h10) begin errors++; $display("FAIL release_pc_id: got %h exp %h", pc_id, 32'h10); end
    checks++; if (inst_id !== mem_word(32'h10)) begin errors++; $display("FAIL release_inst: got %h exp %h", inst_id, mem_word(32'h10)); end
    checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL release_valid: got %b exp 1", valid_id); end
    checks++; if (imem_bus.imem_addr !== 32'h14) begin errors++; $display("FAIL release_addr: got %h exp %h", imem_bus.imem_addr, 32'h14); end
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %b exp 1", imem_bus.imem_req); end
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'h14 + 32'(4 * k);
      ready_drv = 1'b0;
      for (int w = 0; w < 2; w++) begin
        step();
        checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL ws_valid: got %b exp 0", valid_id); end
        checks++; if (inst_id !== NOP) begin errors++; $display("FAIL ws_inst: got %h exp %h", inst_id, NOP); end
        checks++; if (imem_bus.imem_addr !== a) begin errors++; $display("FAIL ws_addr: got %h exp %h", imem_bus.imem_addr, a); end
      end
      ready_drv = 1'b1;
      step();
      checks++; if (pc_id !== a) begin errors++; $display("FAIL ws_pc_id: got %h exp %h", pc_id, a); end
      checks++; if (inst_id !== mem_word(a)) begin errors++; $display("FAIL ws_data: got %h exp %h", inst_id, mem_word(a)); end
      checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL ws_valid_hit: got %b exp 1", valid_id); end
    end
    ready_drv = 1'b0;
  endtask

  task automatic test_branch_drain();
    branch = 1'b1; target = 32'h0000_0201; fd_flush = 1'b1;
    step();
    checks++; if (st !== 2'd3) begin errors++; $display("FAIL br_state: got %0d exp 3", st); end
    checks++; if (imem_bus.imem_addr !== 32'h24) begin errors++; $display("FAIL br_stale_addr: got %h exp %h", imem_bus.imem_addr, 32'h24); end
    checks++; if (pc_if !== 32'h200) begin errors++; $display("FAIL br_pc_if: got %h exp %h", pc_if, 32'h200); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL br_flush_valid: got %b exp 0", valid_id); end
    checks++; if (pc_id !== 32'h20) begin errors++; $display("FAIL br_flush_pc_id: got %h exp %h", pc_id, 32'h20); end
    branch = 1'b0; fd_flush = 1'b0;
    step();
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL br_drain_req: got %b exp 1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 32'h24) begin errors++; $display("FAIL br_drain_addr: got %h exp %h", imem_bus.imem_addr, 32'h24); end
    ready_drv = 1'b1;
    step();
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL br_discard_valid: got %b exp 0", valid_id); end
    checks++; if (inst_id !== NOP) begin errors++; $display("FAIL br_discard_inst: got %h exp %h", inst_id, NOP); end
    checks++; if (imem_bus.imem_addr !== 32'h200) begin errors++; $display("FAIL br_target_addr: got %h exp %h", imem_bus.imem_addr, 32'h200); end
    step();
    checks++; if (pc_id !== 32'h200) begin errors++; $display("FAIL br_target_pc_id: got %h exp %h", pc_id, 32'h200); end
    checks++; if (inst_id !== mem_word(32'h200)) begin errors++; $display("FAIL br_target_inst: got %h exp %h", inst_id, mem_word(32'h200)); end
    checks++; if (imem_bus.imem_addr !== 32'h204) begin errors++; $display("FAIL br_next_addr: got %h exp %h", imem_bus.imem_addr, 32'h204); end
    ready_drv = 1'b0;
  endtask

  task automatic test_ignored();
    pc_en = 1'b0; branch = 1'b1; target = 32'h300; fd_en = 1'b0; fd_flush = 1'b1;
    step();
    checks++; if (pc_if !== 32'h204) begin errors++; $display("FAIL ign_pc_if: got %h exp %h", pc_if, 32'h204); end
    checks++; if (pc_id !== 32'h200) begin errors++; $display("FAIL ign_pc_id: got %h exp %h", pc_id, 32'h200); end
    checks++; if (inst_id !== mem_word(32'h200)) begin errors++; $display("FAIL ign_inst: got %h exp %h", inst_id, mem_word(32'h200)); end
    checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL ign_valid: got %b exp 1", valid_id); end
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL ign_state: got %0d exp 1", st); end
    pc_en = 1'b1; branch = 1'b0; fd_en = 1'b1; fd_flush = 1'b0;
  endtask

  task automatic test_fetch_hit_redirect();
    ready_drv = 1'b1; branch = 1'b1; target = 32'h400;
    step();
    checks++; if (pc_if !== 32'h400) begin errors++; $display("FAIL fhr_pc_if: got %h exp %h", pc_if, 32'h400); end
    checks++; if (imem_bus.imem_addr !== 32'h400) begin errors++; $display("FAIL fhr_addr: got %h exp %h", imem_bus.imem_addr, 32'h400); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL fhr_valid: got %b exp 0", valid_id); end
    checks++; if (inst_id !== NOP) begin errors++; $display("FAIL fhr_inst: got %h exp %h", inst_id, NOP); end
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL fhr_state: got %0d exp 1", st); end
    branch = 1'b0; ready_drv = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    rst = 1'b1;
    #1;
    checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL rm_pc_if: got %h exp %h", pc_if, 32'h0); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b exp 0", valid_id); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", imem_bus.imem_req); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL rm_state: got %0d exp 0", st); end
    ready_drv = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rm_idle_valid: got %b exp 0", valid_id); end
    checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart_addr: got %h exp %h", imem_bus.imem_addr, 32'h0); end
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL rm_restart_req: got %b exp 1", imem_bus.imem_req); end
    step();
    checks++; if (pc_id !== 32'h0) begin errors++; $display("FAIL rm_first_pc_id: got %h exp %h", pc_id, 32'h0); end
    checks++; if (inst_id !== mem_word(32'h0)) begin errors++; $display("FAIL rm_first_inst: got %h exp %h", inst_id, mem_word(32'h0)); end
    checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL rm_first_valid: got %b exp 1", valid_id); end
    ready_drv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_hold();
    test_wait_states();
    test_branch_drain();
    test_ignored();
    test_fetch_hit_redirect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage with the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and the decode stage. It holds the PC and issues requests to a variable-latency instruction memory. It buffers a returned instruction while ID is stalled, applies branch redirects and FD flushes, and presents PC_ID/inst_ID/valid_ID to decode. It consumes PC_EN_IF, reg_FD_EN, reg_FD_stall and reg_FD_flush from the hazard unit, and Branch_ID/PC_target_ID from decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction injected on bubble/flush (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
PC_EN_IF  in  1  1 = PC may advance/redirect; 0 = stall
reg_FD_EN  in  1  0 freezes IF/ID register completely
reg_FD_stall  in  1  1 = hold IF/ID contents
reg_FD_flush  in  1  1 = load bubble into IF/ID
Branch_ID  in  1  taken branch/jump resolved in ID
PC_target_ID  in  32  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (word aligned)
imem_ready  in  1  response valid this cycle
imem_rdata  in  32  instruction, valid when imem_ready
PC_IF  out  32  current fetch PC
PC_ID  out  32  IF/ID PC
inst_ID  out  32  IF/ID instruction
valid_ID  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, immediate): PC_IF=RESET_PC; PC_ID=0; inst_ID=NOP_INST; valid_ID=0; imem_req=0; state=IDLE; buffer empty.
- States:
  - IDLE: only the first cycle after reset deassertion; goes to FETCH.
  - FETCH: request outstanding.
  - HOLD: instruction buffered, ID stalled.
  - DRAIN: redirected while a request is outstanding; the response must be discarded.
- imem protocol:
  - imem_req=1 in FETCH and DRAIN, else 0.
  - imem_addr = PC_IF in FETCH, and the stale address in DRAIN.
  - Address and request are held stable until imem_ready.
  - Only one request is outstanding at a time.
  - imem_ready is ignored when imem_req=0.
- "Advance" = PC_EN_IF & ~reg_FD_stall & reg_FD_EN.
- FETCH with imem_ready & advance & ~Branch_ID:
  - IF/ID <= {PC_IF, imem_rdata, valid=1}; PC_IF <= PC_IF+4 (32-bit wrap).
  - Stay in FETCH; the new request is asserted next cycle.
  - A zero-wait memory (ready in the same cycle as req) sustains 1 instruction/cycle.
- FETCH with imem_ready & ~advance: capture {PC_IF, imem_rdata} in the buffer and go to HOLD; PC_IF is unchanged.
- HOLD & advance: IF/ID <= buffer with valid=1; PC_IF += 4; go to FETCH.
- FETCH with ~imem_ready & advance: IF/ID <= {PC_IF, NOP_INST, valid=0} (bubble).
- Branch_ID is acted on only when PC_EN_IF=1; when PC_EN_IF=0 it is ignored. On a redirect, PC_IF <= PC_target_ID and:
  - FETCH & ~imem_ready: go to DRAIN.
  - FETCH & imem_ready: the data is discarded and the machine stays in FETCH on the target.
  - HOLD: the buffer is discarded and the machine goes to FETCH.
- DRAIN: on imem_ready the data is discarded and the machine goes to FETCH (target). A second Branch_ID in DRAIN only updates PC_IF.
- IF/ID priority, per edge:
  1. reg_FD_EN=0: hold everything.
  2. reg_FD_flush: {PC_ID unchanged, NOP_INST, valid=0}.
  3. reg_FD_stall: hold.
  4. Otherwise load per the rules above.
- Flush does not by itself cancel a fetch. Only Branch_ID redirects the PC.
- imem_rdata is never written to IF/ID while in DRAIN.
- PC_target_ID bits [1:0] are forced to 0.
- Reset asserted mid-request: state returns to IDLE immediately; any later imem_ready is ignored until FETCH re-entry.

Test Plan:
- Zero-wait memory (imem_ready=imem_req), no stalls, RESET_PC=0 -> imem_addr 0,4,8,12 on consecutive cycles; PC_ID/inst_ID follow one cycle later with valid_ID=1 each cycle.
- 2-wait-state memory -> each fetched instruction is preceded by 2 cycles of valid_ID=0/inst_ID=0x00000013; imem_addr held stable across wait cycles.
- Instruction returns at PC=0x10 while reg_FD_stall=1, PC_EN_IF=0 for 3 cycles -> state HOLD, imem_req=0, PC_IF stays 0x10, IF/ID unchanged; on release IF/ID = {0x10, data}, next imem_addr=0x14.
- Branch_ID=1, PC_target_ID=0x200 while request to 0x24 is outstanding, ready 2 cycles later -> 0x24 data never reaches IF/ID; next imem_addr=0x200; reg_FD_flush in the same cycle gives valid_ID=0.
- Branch_ID=1 with PC_EN_IF=0 -> ignored, PC_IF unchanged; reg_FD_EN=0 with flush=1 -> IF/ID held.
- rst pulsed during an outstanding request -> immediately PC_IF=RESET_PC, valid_ID=0, imem_req=0; fetch restarts at RESET_PC two cycles after release.
